// File: rtl/reg_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_share_arbiter_if
//   Bundles the requester-side and register-side signals of reg_share_arbiter.
//
//   Handshake: req[i] is requester i's "valid". It is held high, with
//   wdata[i*W +: W] stable, until ack[i] pulses for one cycle (the write has
//   landed in q). ack is the only "ready/done" indication. Dropping req[i]
//   before ack[i] abandons the request; an in-flight grant is then aborted
//   without writing q.
//
//   Ports (grouped):
//     req      N    per-requester write request
//     wdata    N*W  per-requester write data, slice i = wdata[i*W +: W]
//     gnt      N    one-hot grant, zero when idle
//     ack      N    one-hot, one-cycle write confirmation
//     q        W    shared register contents
//     busy     1    arbiter not idle
//     wr_count 16   completed-write counter (wraps)
//
//   master: the requester side (drives req/wdata).
//   slave : the arbiter side (drives gnt/ack/q/busy/wr_count).
// ---------------------------------------------------------------------------
interface reg_share_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic           busy;
  logic [15:0]    wr_count;

  modport master (
    output req, wdata,
    input  gnt, ack, q, busy, wr_count
  );

  modport slave (
    input  req, wdata,
    output gnt, ack, q, busy, wr_count
  );
endinterface

// File: rtl/reg_share_arbiter.sv
// ---------------------------------------------------------------------------
// reg_share_arbiter
//   N requesters share one W-bit register q. A three-state FSM
//   (IDLE -> GRANT -> DONE -> IDLE) grants one requester at a time in
//   round-robin order, writes its data into q and acknowledges it.
//
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous, active-high reset
//     bus        reg_share_arbiter_if.slave (req/wdata in; gnt/ack/q/busy/
//                wr_count out)
//     state_dbg  current FSM state (0 IDLE, 1 GRANT, 2 DONE) for checkers
// ---------------------------------------------------------------------------
module reg_share_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,
  reg_share_arbiter_if.slave  bus,
  output logic [1:0]          state_dbg
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_n;
  // sel is both the current grantee (while GRANT/DONE) and the round-robin
  // "last granted" pointer: it is loaded on every entry to GRANT, so aborted
  // grants advance fairness too. Reset value N-1 makes requester 0 win first.
  logic [IW-1:0] sel;
  logic [IW-1:0] pick;
  logic          pick_valid;
  logic [W-1:0]  q_r;
  logic [15:0]   wr_count_r;
  // Cleared by reset, set by the first edge after reset releases. IDLE does
  // not grant until it is set, so the earliest grant is on the second edge.
  logic          armed;
  logic [N-1:0]  sel_onehot;

  // Round-robin search starting at sel+1, wrapping modulo N.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = sel;
    pick_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(sel) + k) % N;
      if (!pick_valid && bus.req[idx]) begin
        pick_valid = 1'b1;
        pick       = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (armed && pick_valid) state_n = GRANT;
      // Requester still asking at the closing edge: write; otherwise abort.
      GRANT:   state_n = bus.req[sel] ? DONE : IDLE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      sel        <= IW'(N - 1);
      q_r        <= '0;
      wr_count_r <= '0;
    end else begin
      armed <= 1'b1;
      if (state == IDLE && state_n == GRANT) begin
        sel <= pick;
      end
      if (state == GRANT && state_n == DONE) begin
        q_r        <= bus.wdata[sel*W +: W];
        wr_count_r <= wr_count_r + 16'd1;
      end
    end
  end

  assign sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel;

  assign bus.gnt      = (state == GRANT || state == DONE) ? sel_onehot : '0;
  assign bus.ack      = (state == DONE) ? sel_onehot : '0;
  assign bus.q        = q_r;
  assign bus.busy     = (state != IDLE);
  assign bus.wr_count = wr_count_r;
  assign state_dbg    = state;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_share_arbiter
//   Directed testbench for reg_share_arbiter (N=4, W=8). Inputs are driven
//   and outputs sampled on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_reg_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_q[$];

  reg_share_arbiter_if #(.N(N), .W(W)) bus ();

  reg_share_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want 00", bus.q); end
    n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", bus.ack); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.wr_count !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_count: got %h want 0000", bus.wr_count); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    // Release with a request pending: no grant may appear at the first edge.
    reset = 1'b0;
    bus.req = 4'b0001;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_first_edge: gnt %b busy %b want 0000 0", bus.gnt, bus.busy); end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.req = 4'b0001;
    bus.wdata = 32'h0000_00A5;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", bus.gnt); end
    n_checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_grant_phase: ack %b busy %b want 0000 1", bus.ack, bus.busy); end
    n_checks++; if (bus.q !== 8'h00) begin n_fail++; $display("FAIL single_q_early: got %h want 00", bus.q); end
    @(negedge clk);
    n_checks++; if (bus.q !== 8'hA5) begin n_fail++; $display("FAIL single_q: got %h want a5", bus.q); end
    n_checks++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", bus.ack); end
    n_checks++; if (bus.wr_count !== 16'd1) begin n_fail++; $display("FAIL single_wr_count: got %0d want 1", bus.wr_count); end
    bus.req = '0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.ack !== 4'b0000) begin n_fail++; $display("FAIL single_idle: busy %b gnt %b ack %b want 0 0000 0000", bus.busy, bus.gnt, bus.ack); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g;
    logic [W-1:0] exp_d;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) exp_q.push_back(4'b0001 << i);
    bus.wdata = 32'h4433_2211;
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_g = exp_q.pop_front();
      exp_d = 8'((i % 4 + 1) * 17);
      n_checks++; if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL fair_gnt[%0d]: got %b want %b", i, bus.gnt, exp_g); end
      @(negedge clk);
      n_checks++; if (bus.ack !== exp_g || bus.q !== exp_d) begin n_fail++; $display("FAIL fair_ack[%0d]: ack %b q %h want %b %h", i, bus.ack, bus.q, exp_g, exp_d); end
      @(negedge clk);
      if (i == 7) bus.req = '0;
    end
    n_checks++; if (bus.wr_count !== 16'd8 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL fair_wr_count: got %0d busy %b want 8 0", bus.wr_count, bus.busy); end
  endtask

  task automatic test_abort();
    bus.req = 4'b0100;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL abort_gnt: got %b want 0100", bus.gnt); end
    bus.req = 4'b0000;
    @(negedge clk);
    n_checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL abort_idle: ack %b busy %b gnt %b want 0000 0 0000", bus.ack, bus.busy, bus.gnt); end
    n_checks++; if (bus.q !== 8'h44 || bus.wr_count !== 16'd8) begin n_fail++; $display("FAIL abort_state: q %h wr_count %0d want 44 8", bus.q, bus.wr_count); end
    bus.req = 4'b1111;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL abort_next_gnt: got %b want 1000", bus.gnt); end
    @(negedge clk);
    n_checks++; if (bus.ack !== 4'b1000 || bus.wr_count !== 16'd9) begin n_fail++; $display("FAIL abort_next_ack: ack %b wr_count %0d want 1000 9", bus.ack, bus.wr_count); end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bus.req = 4'b0010;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL midrst_gnt: got %b want 0010", bus.gnt); end
    @(negedge clk);
    n_checks++; if (bus.ack !== 4'b0010 || bus.q !== 8'h22) begin n_fail++; $display("FAIL midrst_done: ack %b q %h want 0010 22", bus.ack, bus.q); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.ack !== 4'b0000 || bus.gnt !== 4'b0000 || bus.q !== 8'h00) begin n_fail++; $display("FAIL midrst_async: ack %b gnt %b q %h want 0000 0000 00", bus.ack, bus.gnt, bus.q); end
    n_checks++; if (state_dbg !== 2'd0 || bus.busy !== 1'b0 || bus.wr_count !== 16'd0) begin n_fail++; $display("FAIL midrst_state: state %0d busy %b wr_count %0d want 0 0 0", state_dbg, bus.busy, bus.wr_count); end
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b1111;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL midrst_first_edge: got %b want 0000", bus.gnt); end
    @(negedge clk);
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_next_gnt: got %b want 0001", bus.gnt); end
    @(negedge clk);
    n_checks++; if (bus.ack !== 4'b0001 || bus.q !== 8'h11) begin n_fail++; $display("FAIL midrst_next_ack: ack %b q %h want 0001 11", bus.ack, bus.q); end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_isolation();
    bus.wdata = 32'h0102_5A03;
    bus.req = 4'b0010;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL iso_gnt: got %b want 0010", bus.gnt); end
    bus.wdata = 32'hC396_5A3C;
    bus.req = 4'b1011;
    #2 bus.wdata = 32'hFFFF_5AFF;
    @(negedge clk);
    n_checks++; if (bus.q !== 8'h5A) begin n_fail++; $display("FAIL iso_q: got %h want 5a", bus.q); end
    n_checks++; if (bus.ack !== 4'b0010 || bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL iso_ack: ack %b gnt %b want 0010 0010", bus.ack, bus.gnt); end
    bus.req = '0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.q !== 8'h5A) begin n_fail++; $display("FAIL iso_idle: busy %b q %h want 0 5a", bus.busy, bus.q); end
  endtask

  task automatic test_back_to_back();
    bus.wdata = 32'hB300_B100;
    bus.req = 4'b1010;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL b2b_gnt0: got %b want 1000", bus.gnt); end
    @(negedge clk);
    n_checks++; if (bus.ack !== 4'b1000 || bus.q !== 8'hB3) begin n_fail++; $display("FAIL b2b_ack0: ack %b q %h want 1000 b3", bus.ack, bus.q); end
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle0: busy %b want 0", bus.busy); end
    @(negedge clk);
    // req[3] is still high, but round-robin must move on to requester 1.
    n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL b2b_gnt1: got %b want 0010", bus.gnt); end
    @(negedge clk);
    n_checks++; if (bus.ack !== 4'b0010 || bus.q !== 8'hB1) begin n_fail++; $display("FAIL b2b_ack1: ack %b q %h want 0010 b1", bus.ack, bus.q); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL b2b_gnt2: got %b want 1000", bus.gnt); end
    bus.req = '0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.q !== 8'hB1 || bus.wr_count !== 16'd4) begin n_fail++; $display("FAIL b2b_abort: busy %b q %h wr_count %0d want 0 b1 4", bus.busy, bus.q, bus.wr_count); end
  endtask

  task automatic test_wrap();
    force dut.wr_count_r = 16'hFFFF;
    #1 release dut.wr_count_r;
    n_checks++; if (bus.wr_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", bus.wr_count); end
    bus.wdata = 32'h0000_0077;
    bus.req = 4'b0001;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt: got %b want 0001", bus.gnt); end
    @(negedge clk);
    n_checks++; if (bus.wr_count !== 16'h0000 || bus.q !== 8'h77) begin n_fail++; $display("FAIL wrap_count: wr_count %h q %h want 0000 77", bus.wr_count, bus.q); end
    bus.req = '0;
    @(negedge clk);
    n_checks++; if (bus.wr_count !== 16'h0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: wr_count %h busy %b want 0000 0", bus.wr_count, bus.busy); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.wdata = '0;
    test_reset();
    test_single();
    test_fairness();
    test_abort();
    test_mid_reset();
    test_isolation();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter W, default 8: width of the shared data register.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  N  per-requester write request; bit i is held high until ack[i] or until abandoned.
REQ-006 wdata  input  N*W  per-requester write data; slice i is wdata[i*W +: W].
REQ-007 gnt  output  N  one-hot grant; all zero when no grant is active.
REQ-008 ack  output  N  one-hot, one-cycle pulse confirming the write of requester i.
REQ-009 q  output  W  shared register contents; registered.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 wr_count  output  16  count of completed writes.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and DONE.
REQ-013 In IDLE with req != 0, the block SHALL select one requester by round-robin and, at the next edge, enter GRANT with gnt set to that requester's one-hot bit.
REQ-014 Round-robin order: search starts at (last+1) mod N and wraps; last is the index most recently granted.
REQ-015 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0 and ack = 0.
REQ-016 In GRANT, at the closing edge:
  - if req[g] is still high: q <= wdata slice g, and the state moves to DONE;
  - if req[g] is low: abort; q is unchanged, there is no ack, wr_count is unchanged, and the state moves to IDLE.
REQ-017 In DONE: ack[g] = 1 for exactly one cycle, gnt stays at g, and the next state is IDLE.
REQ-018 gnt SHALL be nonzero only in the GRANT and DONE states; ack SHALL be nonzero only in DONE.
REQ-019 last SHALL update to g on entry to GRANT, so that aborted grants also advance fairness.
REQ-020 Timing:
  - req seen in IDLE at cycle t gives gnt at t+1, new q and ack at t+2, and IDLE at t+3;
  - maximum throughput is one write per 3 cycles.
REQ-021 wr_count SHALL increment by 1 on each GRANT->DONE transition and wrap from 0xFFFF to 0x0000.
REQ-022 Changes to req[j] for j != g, or to wdata[j] for j != g, SHALL have no effect during GRANT or DONE.
REQ-023 If req[g] is still high in the cycle after DONE, it SHALL be treated as a new request subject to round-robin, not as an immediate re-grant.
REQ-024 q SHALL change only on a GRANT->DONE transition or on reset.

Reset
REQ-025 While reset is high, the outputs SHALL be:
  - state = IDLE;
  - q = 0, gnt = 0, ack = 0, busy = 0, wr_count = 0;
  - last = N-1, so requester 0 wins first.
REQ-026 A reset asserted in GRANT or DONE SHALL take effect immediately and asynchronously: no write completes, no ack is emitted, and q returns to 0.
REQ-027 After reset deasserts, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-028 Single request (N=4, W=8): after reset, req=0001 and wdata[7:0]=0xA5 -> gnt=0001 at t+1; q=0xA5, ack=0001 and wr_count=1 at t+2; busy=0 at t+3.
REQ-029 Fairness: req=1111 held, re-asserted after each ack -> grant order 0,1,2,3,0,1,2,3; wr_count=8 after 24 cycles.
REQ-030 Abort: req=0100 granted, req[2] dropped during GRANT -> no ack, q unchanged, wr_count unchanged; the next grant with req=1111 goes to requester 3.
REQ-031 Mid-operation reset: reset pulsed while in DONE -> ack, gnt and q immediately 0, state IDLE, and the next grant goes to requester 0.
REQ-032 Counter wrap: wr_count forced by 65536 completed writes (or a backdoor preload to 0xFFFF) plus one more write -> wr_count = 0x0000.
REQ-033 Isolation: during requester 1's GRANT, toggle wdata slices 0, 2 and 3 -> q equals wdata slice 1 only.
